reset_seq: RTL

//   6502 reset sequencer; sits directly downstream of porf_gen and consumes its sync_reset.

---
 rtl/reset_seq_if.sv | 23 ++
 rtl/reset_seq.sv | 127 ++++++++++++
 2 files changed

// File: rtl/reset_seq_if.sv
// Memory read bus plus the CPU start-up values produced by reset_seq.
// master: the sequencer (drives address/strobe and start-up values); slave: memory/core side.
// mem_rd_data is returned one enabled cycle after mem_rd_en and is held across disabled cycles.
interface reset_seq_if;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data;
    logic [15:0] pc_init;
    logic [7:0]  sp_init;
    logic [7:0]  p_init;
    logic        busy;
    logic        cpu_start;

    modport master (
        output mem_addr, mem_rd_en, pc_init, sp_init, p_init, busy, cpu_start,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr, mem_rd_en, pc_init, sp_init, p_init, busy, cpu_start,
        output mem_rd_data
    );
endinterface

// File: rtl/reset_seq.sv
// 6502 reset sequencer: dummy cycles, reset-vector fetch, then hands PC/SP/P to the core.
// Latency: cpu_start rises on enabled edge DUMMY_CYCLES+4 after async_reset release (9 by default).
// Backpressure: none; clk_enable=0 freezes every register (memory holds read data likewise).
// Ports: clk, async_reset (async, active-high), clk_enable, bus (reset_seq_if.master:
//   mem_addr/mem_rd_en out, mem_rd_data in, pc_init/sp_init/p_init/busy/cpu_start out).
// Option: define RESET_SEQ_DUMMY_READS_EN to emit 6502-style dummy/stack reads during DUMMY.
module reset_seq #(
    parameter logic [15:0] VECTOR_ADDR  = 16'hFFFC,
    parameter int          DUMMY_CYCLES = 5,
    parameter logic [7:0]  SP_INIT      = 8'hFD,
    parameter logic [7:0]  P_INIT       = 8'h24
) (
    input  logic          clk,
    input  logic          async_reset,
    input  logic          clk_enable,
    reset_seq_if.master   bus
);

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        DUMMY  = 3'd1,
        VEC_LO = 3'd2,
        VEC_HI = 3'd3,
        LOAD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0]  CNT_LAST     = 4'(DUMMY_CYCLES - 1);
    // 16-bit add so a vector at FFFF fetches its high byte from 0000.
    localparam logic [15:0] VECTOR_ADDR1 = VECTOR_ADDR + 16'd1;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] pc_init;
    logic [7:0]  sp_init;
    logic [7:0]  p_init;
    logic        busy;
    logic        cpu_start;

`ifdef RESET_SEQ_DUMMY_READS_EN
    // Address for the next DUMMY cycle (index cnt+1): index 1 repeats 0000,
    // index k>=2 reads the stack at 0x0100 + (8'h00 - (k-2)), i.e. SP 00, FF, FE...
    logic [15:0] dummy_addr;
    always_comb begin
        dummy_addr = 16'h0000;
        if (cnt != 4'd0) begin
            dummy_addr = {8'h01, 8'h01 - {4'h0, cnt}};
        end
    end
`endif

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state     <= HOLD;
            cnt       <= 4'd0;
            mem_addr  <= 16'h0000;
            mem_rd_en <= 1'b0;
            pc_init   <= 16'h0000;
            sp_init   <= 8'h00;
            p_init    <= 8'h00;
            busy      <= 1'b0;
            cpu_start <= 1'b0;
        end else if (clk_enable) begin
            case (state)
                HOLD: begin
                    state <= DUMMY;
                    busy  <= 1'b1;
                    cnt   <= 4'd0;
`ifdef RESET_SEQ_DUMMY_READS_EN
                    mem_addr  <= 16'h0000;
                    mem_rd_en <= 1'b1;
`endif
                end
                DUMMY: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state     <= VEC_LO;
                        mem_addr  <= VECTOR_ADDR;
                        mem_rd_en <= 1'b1;
                    end else begin
`ifdef RESET_SEQ_DUMMY_READS_EN
                        mem_addr  <= dummy_addr;
                        mem_rd_en <= 1'b1;
`endif
                    end
                end
                VEC_LO: begin
                    state     <= VEC_HI;
                    mem_addr  <= VECTOR_ADDR1;
                    mem_rd_en <= 1'b1;
                end
                VEC_HI: begin
                    // Low byte returns during this cycle.
                    pc_init[7:0] <= bus.mem_rd_data;
                    state        <= LOAD;
                    mem_rd_en    <= 1'b0;
                    mem_addr     <= 16'h0000;
                end
                LOAD: begin
                    pc_init[15:8] <= bus.mem_rd_data;
                    state         <= DONE;
                    sp_init       <= SP_INIT;
                    p_init        <= P_INIT;
                    cpu_start     <= 1'b1;
                    busy          <= 1'b0;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_rd_en = mem_rd_en;
    assign bus.pc_init   = pc_init;
    assign bus.sp_init   = sp_init;
    assign bus.p_init    = p_init;
    assign bus.busy      = busy;
    assign bus.cpu_start = cpu_start;

endmodule
